// File: rtl/frog_controller.sv
// Frog game-state stage: grid position, lives, death/respawn/crossing/game-over sequencing.
// Optional post-respawn invulnerability with blink is enabled by defining FROG_INVULN_EN.
module frog_controller #(
  parameter int unsigned GRID_COLS     = 20,
  parameter int unsigned GRID_ROWS     = 15,
  parameter int unsigned START_COL     = 10,
  parameter int unsigned START_ROW     = 14,
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned MOVE_FRAMES   = 8,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       car_hit,
  output logic [4:0] frog_col,
  output logic [3:0] frog_row,
  output logic [1:0] lives,
  output logic       frog_visible,
  output logic       crossed,
  output logic       game_over
);

  localparam logic [2:0] S_PLAY     = 3'd0;
  localparam logic [2:0] S_COOL     = 3'd1;
  localparam logic [2:0] S_DEAD     = 3'd2;
  localparam logic [2:0] S_GAMEOVER = 3'd3;
  localparam logic [2:0] S_CROSS    = 3'd4;

  localparam logic [4:0] LP_START_COL  = 5'(START_COL);
  localparam logic [3:0] LP_START_ROW  = 4'(START_ROW);
  localparam logic [4:0] LP_MAX_COL    = 5'(GRID_COLS - 1);
  localparam logic [3:0] LP_MAX_ROW    = 4'(GRID_ROWS - 1);
  localparam logic [1:0] LP_INIT_LIVES = 2'(INIT_LIVES);
  localparam logic [7:0] LP_MOVE_LAST  = 8'(MOVE_FRAMES - 1);
  localparam logic [7:0] LP_DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] LP_INV_LAST   = 8'(INVULN_FRAMES - 1);

`ifdef FROG_INVULN_EN
  localparam bit LP_INV_EN = 1'b1;
`else
  localparam bit LP_INV_EN = 1'b0;
`endif

  logic [2:0] r_state;
  logic [4:0] r_col;
  logic [3:0] r_row;
  logic [1:0] r_lives;
  logic       r_visible;
  logic       r_crossed;
  logic       r_game_over;
  logic [7:0] r_cnt;
  logic [3:0] r_btn_prev;
  logic       r_inv_act;
  logic [7:0] r_inv_cnt;

  logic [3:0] w_btn;
  logic [3:0] w_press;
  logic [4:0] w_tgt_col;
  logic [3:0] w_tgt_row;
  logic       w_mv_ok;
  logic       w_shielded;

  logic [2:0] w_nxt_state;
  logic [4:0] w_nxt_col;
  logic [3:0] w_nxt_row;
  logic [1:0] w_nxt_lives;
  logic       w_nxt_crossed;
  logic [7:0] w_nxt_cnt;
  logic       w_respawn;
  logic       w_nxt_inv_act;
  logic [7:0] w_nxt_inv_cnt;
  logic       w_blink_on;
  logic       w_nxt_visible;
  logic       w_nxt_game_over;

  // Bit order {up, down, left, right}; press = rising edge versus last cycle.
  assign w_btn      = {btn_up, btn_down, btn_left, btn_right};
  assign w_press    = w_btn & ~r_btn_prev;
  assign w_shielded = LP_INV_EN & r_inv_act;

  // Highest-priority press picks the single candidate move; range check clamps it.
  always_comb begin
    w_tgt_col = r_col;
    w_tgt_row = r_row;
    w_mv_ok   = 1'b0;
    if (w_press[3]) begin
      w_tgt_row = r_row - 4'd1;
      w_mv_ok   = (r_row != '0);
    end else if (w_press[2]) begin
      w_tgt_row = r_row + 4'd1;
      w_mv_ok   = (r_row < LP_MAX_ROW);
    end else if (w_press[1]) begin
      w_tgt_col = r_col - 5'd1;
      w_mv_ok   = (r_col != '0);
    end else if (w_press[0]) begin
      w_tgt_col = r_col + 5'd1;
      w_mv_ok   = (r_col < LP_MAX_COL);
    end
  end

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_col     = r_col;
    w_nxt_row     = r_row;
    w_nxt_lives   = r_lives;
    w_nxt_crossed = 1'b0;
    w_nxt_cnt     = r_cnt;
    w_respawn     = 1'b0;
    case (r_state)
      S_PLAY, S_COOL: begin
        if (car_hit && !w_shielded) begin
          w_nxt_cnt = '0;
          if (r_lives > 2'd1) begin
            w_nxt_lives = r_lives - 2'd1;
            w_nxt_state = S_DEAD;
          end else begin
            w_nxt_lives = '0;
            w_nxt_state = S_GAMEOVER;
          end
        end else if (r_state == S_PLAY) begin
          if (w_mv_ok) begin
            w_nxt_col = w_tgt_col;
            w_nxt_row = w_tgt_row;
            w_nxt_cnt = '0;
            if (w_tgt_row == '0) begin
              w_nxt_crossed = 1'b1;
              w_nxt_state   = S_CROSS;
            end else begin
              w_nxt_state = S_COOL;
            end
          end
        end else if (frame_tick) begin
          if (r_cnt == LP_MOVE_LAST) begin
            w_nxt_cnt   = '0;
            w_nxt_state = S_PLAY;
          end else begin
            w_nxt_cnt = r_cnt + 8'd1;
          end
        end
      end
      S_CROSS: begin
        w_nxt_col   = LP_START_COL;
        w_nxt_row   = LP_START_ROW;
        w_nxt_cnt   = '0;
        w_nxt_state = S_COOL;
        w_respawn   = 1'b1;
      end
      S_DEAD: begin
        if (frame_tick) begin
          if (r_cnt == LP_DEATH_LAST) begin
            w_nxt_col   = LP_START_COL;
            w_nxt_row   = LP_START_ROW;
            w_nxt_cnt   = '0;
            w_nxt_state = S_PLAY;
            w_respawn   = 1'b1;
          end else begin
            w_nxt_cnt = r_cnt + 8'd1;
          end
        end
      end
      S_GAMEOVER: begin
        if (|w_press) begin
          w_nxt_col   = LP_START_COL;
          w_nxt_row   = LP_START_ROW;
          w_nxt_lives = LP_INIT_LIVES;
          w_nxt_cnt   = '0;
          w_nxt_state = S_PLAY;
          w_respawn   = 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_PLAY;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // Invulnerability window runs across PLAY/COOL independently of the state counter.
  always_comb begin
    w_nxt_inv_act = r_inv_act;
    w_nxt_inv_cnt = r_inv_cnt;
    if (r_inv_act && frame_tick) begin
      if (r_inv_cnt == LP_INV_LAST) begin
        w_nxt_inv_act = 1'b0;
        w_nxt_inv_cnt = '0;
      end else begin
        w_nxt_inv_cnt = r_inv_cnt + 8'd1;
      end
    end
    if (w_respawn && LP_INV_EN) begin
      w_nxt_inv_act = 1'b1;
      w_nxt_inv_cnt = '0;
    end
  end

  always_comb begin
    w_blink_on      = !w_nxt_inv_act || !w_nxt_inv_cnt[3];
    w_nxt_game_over = (w_nxt_state == S_GAMEOVER);
    w_nxt_visible   = (w_nxt_state != S_DEAD) && !w_nxt_game_over && w_blink_on;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_PLAY;
      r_col       <= LP_START_COL;
      r_row       <= LP_START_ROW;
      r_lives     <= LP_INIT_LIVES;
      r_visible   <= 1'b1;
      r_crossed   <= 1'b0;
      r_game_over <= 1'b0;
      r_cnt       <= '0;
      r_btn_prev  <= '0;
      r_inv_act   <= 1'b0;
      r_inv_cnt   <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_col       <= w_nxt_col;
      r_row       <= w_nxt_row;
      r_lives     <= w_nxt_lives;
      r_visible   <= w_nxt_visible;
      r_crossed   <= w_nxt_crossed;
      r_game_over <= w_nxt_game_over;
      r_cnt       <= w_nxt_cnt;
      r_btn_prev  <= w_btn;
      r_inv_act   <= w_nxt_inv_act;
      r_inv_cnt   <= w_nxt_inv_cnt;
    end
  end

  assign frog_col     = r_col;
  assign frog_row     = r_row;
  assign lives        = r_lives;
  assign frog_visible = r_visible;
  assign crossed      = r_crossed;
  assign game_over    = r_game_over;

endmodule
